// File: rtl/picomips_pkg.sv
// picomips_pkg: shared FSM state encoding and NOP word for the program memory.
package picomips_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam int MAX_INSTR_W = 64;
    localparam logic [MAX_INSTR_W-1:0] NOP = '0;

endpackage

// File: rtl/progmem_ram.sv
// progmem_ram: single-port synchronous RAM with write enable and registered read.
module progmem_ram #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset so a program survives a CPU reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/loadable_program_memory.sv
// loadable_program_memory: CPU program store downloaded through a valid/ready stream.
// Define PROGMEM_PARITY_EN to store an even-parity bit per word and expose ParityErr.
module loadable_program_memory
    import picomips_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 10
) (
    input  logic               Clock,
    input  logic               nReset,
    input  logic [ADDR_W-1:0]  Addr,
    output logic [INSTR_W-1:0] Instruction,
    input  logic               LoadStart,
    input  logic               LoadValid,
    input  logic [INSTR_W-1:0] LoadData,
    input  logic               LoadLast,
    output logic               LoadReady,
    output logic               LoadDone,
    output logic               Busy,
`ifdef PROGMEM_PARITY_EN
    output logic               ParityErr,
`endif
    output logic [ADDR_W:0]    WordCount
);

    localparam int DEPTH = 2**ADDR_W;
`ifdef PROGMEM_PARITY_EN
    localparam int MEM_W = INSTR_W + 1;
`else
    localparam int MEM_W = INSTR_W;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   wcount_q, wcount_d;
    logic              hit_q;
    logic              accept, last_word;
    logic [MEM_W-1:0]  wr_word, rd_word;

    assign accept    = (state_q == LOAD) && LoadValid;
    assign last_word = LoadLast || (ptr_q == ADDR_W'(DEPTH-1));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wcount_d = wcount_q;
        unique case (state_q)
            IDLE: if (LoadStart) begin
                state_d  = LOAD;
                ptr_d    = '0;
                wcount_d = '0;
            end
            LOAD: if (accept) begin
                ptr_d = ptr_q + 1'b1;
                if (last_word) begin
                    state_d  = DONE;
                    wcount_d = {1'b0, ptr_q} + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            wcount_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wcount_q <= wcount_d;
            hit_q    <= {1'b0, Addr} < wcount_q;
        end
    end

`ifdef PROGMEM_PARITY_EN
    assign wr_word   = {^LoadData, LoadData};
    assign ParityErr = !Busy && hit_q && (^rd_word);
`else
    assign wr_word = LoadData;
`endif

    // The single port is stolen for writes only while a word is being accepted.
    progmem_ram #(.WIDTH(MEM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk_i  (Clock),
        .we_i   (accept),
        .addr_i (accept ? ptr_q : Addr),
        .wdata_i(wr_word),
        .rdata_o(rd_word)
    );

    assign LoadReady   = (state_q == LOAD);
    assign LoadDone    = (state_q == DONE);
    assign Busy        = (state_q != IDLE);
    assign WordCount   = wcount_q;
    assign Instruction = (Busy || !hit_q) ? NOP[INSTR_W-1:0] : rd_word[INSTR_W-1:0];

endmodule

// File: tb/tb_loadable_program_memory.sv
// tb_loadable_program_memory: table-driven and directed checks of the loadable program memory.
// Build with PROGMEM_PARITY_EN defined to also exercise the parity error output.
module tb_loadable_program_memory;

    logic       Clock = 1'b0;
    logic       nReset, LoadStart, LoadValid, LoadLast;
    logic [4:0] Addr;
    logic [9:0] LoadData, Instruction;
    logic       LoadReady, LoadDone, Busy;
    logic [5:0] WordCount;
`ifdef PROGMEM_PARITY_EN
    logic       ParityErr;
`endif
    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    loadable_program_memory dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .Addr       (Addr),
        .Instruction(Instruction),
        .LoadStart  (LoadStart),
        .LoadValid  (LoadValid),
        .LoadData   (LoadData),
        .LoadLast   (LoadLast),
        .LoadReady  (LoadReady),
        .LoadDone   (LoadDone),
        .Busy       (Busy),
`ifdef PROGMEM_PARITY_EN
        .ParityErr  (ParityErr),
`endif
        .WordCount  (WordCount)
    );

    typedef struct {
        logic       nr, st, v, l;
        logic [4:0] a;
        logic [9:0] d;
        logic [9:0] ei;
        logic       er, ed, eb;
        logic [5:0] ew;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic nr, logic st, logic v, logic l, logic [4:0] a, logic [9:0] d,
                                logic [9:0] ei, logic er, logic ed, logic eb, logic [5:0] ew);
        vec_t r;
        r.nr = nr; r.st = st; r.v = v; r.l = l; r.a = a; r.d = d;
        r.ei = ei; r.er = er; r.ed = ed; r.eb = eb; r.ew = ew;
        return r;
    endfunction

    task automatic step(input logic nr, input logic st, input logic v, input logic l,
                        input logic [4:0] a, input logic [9:0] d);
        nReset = nr; LoadStart = st; LoadValid = v; LoadLast = l; Addr = a; LoadData = d;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [9:0] ei, input logic er, input logic ed,
                       input logic eb, input logic [5:0] ew);
        checks++;
        if (Instruction !== ei || LoadReady !== er || LoadDone !== ed || Busy !== eb || WordCount !== ew) begin
            errors++;
            $display("FAIL %s: got instr=%h rdy=%b done=%b busy=%b wc=%0d, expected instr=%h rdy=%b done=%b busy=%b wc=%0d",
                     nm, Instruction, LoadReady, LoadDone, Busy, WordCount, ei, er, ed, eb, ew);
        end
    endtask

    initial begin
        // reset + first program load
        tbl.push_back(mk(0,0,0,0, 3, 10'h000, 10'h000, 0,0,0, 0));
        tbl.push_back(mk(1,0,0,0, 3, 10'h000, 10'h000, 0,0,0, 0));
        tbl.push_back(mk(1,1,0,0, 3, 10'h000, 10'h000, 1,0,1, 0));
        tbl.push_back(mk(1,0,1,0, 3, 10'h3A1, 10'h000, 1,0,1, 0));
        tbl.push_back(mk(1,0,1,0, 3, 10'h0F2, 10'h000, 1,0,1, 0));
        tbl.push_back(mk(1,0,1,0, 3, 10'h204, 10'h000, 1,0,1, 0));
        tbl.push_back(mk(1,0,1,1, 3, 10'h1FF, 10'h000, 0,1,1, 4));
        tbl.push_back(mk(1,0,0,0, 2, 10'h000, 10'h204, 0,0,0, 4));
        tbl.push_back(mk(1,0,0,0, 4, 10'h000, 10'h000, 0,0,0, 4));
        tbl.push_back(mk(1,0,0,0, 0, 10'h000, 10'h3A1, 0,0,0, 4));
        tbl.push_back(mk(1,0,0,0, 3, 10'h000, 10'h1FF, 0,0,0, 4));
        // reload with LoadValid gaps; idle cycles must not advance the pointer
        tbl.push_back(mk(1,1,0,0, 3, 10'h000, 10'h000, 1,0,1, 0));
        tbl.push_back(mk(1,0,1,0, 3, 10'h011, 10'h000, 1,0,1, 0));
        tbl.push_back(mk(1,0,0,0, 3, 10'h0EE, 10'h000, 1,0,1, 0));
        tbl.push_back(mk(1,0,1,0, 3, 10'h022, 10'h000, 1,0,1, 0));
        tbl.push_back(mk(1,0,0,0, 3, 10'h0EE, 10'h000, 1,0,1, 0));
        tbl.push_back(mk(1,0,0,1, 3, 10'h0EE, 10'h000, 1,0,1, 0));
        tbl.push_back(mk(1,0,1,1, 3, 10'h033, 10'h000, 0,1,1, 3));
        tbl.push_back(mk(1,0,0,0, 0, 10'h000, 10'h011, 0,0,0, 3));
        tbl.push_back(mk(1,0,0,0, 1, 10'h000, 10'h022, 0,0,0, 3));
        tbl.push_back(mk(1,0,0,0, 2, 10'h000, 10'h033, 0,0,0, 3));
        tbl.push_back(mk(1,0,0,0, 3, 10'h000, 10'h000, 0,0,0, 3));
        // LoadValid while idle is ignored
        tbl.push_back(mk(1,0,1,1, 2, 10'h3FF, 10'h033, 0,0,0, 3));
        tbl.push_back(mk(1,0,0,0, 2, 10'h000, 10'h033, 0,0,0, 3));

        foreach (tbl[i]) begin
            step(tbl[i].nr, tbl[i].st, tbl[i].v, tbl[i].l, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d", i), tbl[i].ei, tbl[i].er, tbl[i].ed, tbl[i].eb, tbl[i].ew);
        end

        // full-depth load without LoadLast terminates on word 32
        step(1,1,0,0, 0, 10'h000);
        chk("full_start", 10'h000, 1,0,1, 0);
        for (int i = 0; i < 32; i++) begin
            step(1,0,1,0, 0, 10'(i*7+1));
            if (i < 31) chk($sformatf("full_w%0d", i), 10'h000, 1,0,1, 0);
            else        chk("full_end", 10'h000, 0,1,1, 32);
        end
        step(1,0,0,0, 31, 10'h000);
        chk("full_rd31", 10'd218, 0,0,0, 32);
        step(1,0,0,0, 0, 10'h000);
        chk("full_rd0", 10'd1, 0,0,0, 32);

        // reset aborts a download after 2 of 5 words
        step(1,1,0,0, 0, 10'h000);
        step(1,0,1,0, 0, 10'h155);
        step(1,0,1,0, 0, 10'h2AA);
        chk("abort_mid", 10'h000, 1,0,1, 0);
        step(0,0,1,0, 0, 10'h3FF);
        chk("abort_rst", 10'h000, 0,0,0, 0);
        step(1,0,0,0, 0, 10'h000);
        chk("abort_after", 10'h000, 0,0,0, 0);

        // LoadStart during LOAD must not restart the pointer
        step(1,1,0,0, 0, 10'h000);
        step(1,0,1,0, 0, 10'h101);
        step(1,1,0,0, 0, 10'h000);
        chk("restart_ign", 10'h000, 1,0,1, 0);
        step(1,0,1,1, 0, 10'h102);
        chk("restart_end", 10'h000, 0,1,1, 2);
        step(1,0,0,0, 1, 10'h000);
        chk("restart_rd1", 10'h102, 0,0,0, 2);
        step(1,0,0,0, 0, 10'h000);
        chk("restart_rd0", 10'h101, 0,0,0, 2);

`ifdef PROGMEM_PARITY_EN
        dut.u_ram.mem_q[1][0] = ~dut.u_ram.mem_q[1][0];
        step(1,0,0,0, 1, 10'h000);
        checks++;
        if (ParityErr !== 1'b1) begin
            errors++;
            $display("FAIL par_bad: got ParityErr=%b, expected 1", ParityErr);
        end
        step(1,0,0,0, 0, 10'h000);
        checks++;
        if (ParityErr !== 1'b0) begin
            errors++;
            $display("FAIL par_good: got ParityErr=%b, expected 0", ParityErr);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
